tm1638_key_events: RTL and testbench
====================================

Name: tm1638_key_events

Overview:
- Downstream consumer of the TM1638 controller's key-scan bytes (the 4-byte `tm1638_in` array, refreshed about every 4.7–9 ms).
- Decodes the 8 LED&KEY switches, debounces each key over periodic samples, and reports:
  - a level vector of debounced key states;
  - single-cycle press/release pulses;
  - a valid/ready event FIFO, so application logic never polls raw scan bytes.

Parameters:
- SAMPLE_PERIOD, 32'd250_000: clocks between samples of `tm1638_in` (5 ms at 50 MHz). Must be ≥ 16.
- DEBOUNCE_SAMPLES, 3: consecutive differing samples required to flip a key's debounced state. Range 1..15.
- FIFO_DEPTH, 8: event FIFO entries. Power of 2, ≥ 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-low (asserted when 0).
- tm1638_in  input  [7:0] x4 (unpacked, [4])  key-scan bytes from the TM1638 controller.
- keys_raw  output  8  last sampled, undebounced key vector.
- keys  output  8  debounced key state, 1 = pressed.
- key_pressed  output  8  one-cycle pulse per key on debounced 0→1.
- key_released  output  8  one-cycle pulse per key on debounced 1→0.
- ev_valid  output  1  event FIFO non-empty.
- ev_ready  input  1  consumer accepts the head event.
- ev_pressed  output  1  head event type: 1 = press, 0 = release.
- ev_key  output  3  head event key index 0..7.
- ev_overflow  output  1  sticky: an event was dropped because the FIFO was full.
- ev_overflow_clr  input  1  clears `ev_overflow`.

Behaviour:
- Reset (reset==0 at posedge):
  - keys_raw = 0, keys = 0, key_pressed = 0, key_released = 0.
  - ev_valid = 0, ev_pressed = 0, ev_key = 0, ev_overflow = 0.
  - FIFO emptied, pending mask cleared, debounce counters = 0, sample counter = SAMPLE_PERIOD-1.
  - Reset mid-operation discards all queued and pending events. No release events are generated for keys that were held.
- Key decode (active high):
  - key[i] = tm1638_in[i][0] for i = 0..3.
  - key[i+4] = tm1638_in[i][4] for i = 0..3.
  - All other bits are ignored.
- Sample tick:
  - Down-counter; tick = 1 for one cycle when it is 0, then it reloads SAMPLE_PERIOD-1.
  - First tick occurs SAMPLE_PERIOD cycles after reset release.
- On tick, keys_raw <= decode(tm1638_in). Per key i:
  - If the decoded value equals keys[i], cnt[i] <= 0.
  - Otherwise, if cnt[i] == DEBOUNCE_SAMPLES-1: keys[i] toggles, cnt[i] <= 0, the matching pulse (key_pressed[i] or key_released[i]) asserts in the next cycle only, and pending[i] is set together with its type.
  - Otherwise, cnt[i]++.
  - A single agreeing sample restarts the count.
- Latency:
  - keys[i] changes in the cycle after the DEBOUNCE_SAMPLES-th consecutive differing tick.
  - The pulse is coincident with that change.
- Event serializer:
  - Each cycle, the lowest-index set bit of pending is pushed into the FIFO and cleared.
  - Simultaneous changes are enqueued in ascending key order, one per cycle.
  - SAMPLE_PERIOD ≥ 16 guarantees pending drains before the next tick.
- FIFO:
  - Show-ahead: ev_valid = !empty, and ev_pressed/ev_key reflect the head entry.
  - Pop when ev_valid && ev_ready.
  - Push when full: accepted if a pop occurs in the same cycle; otherwise the event is dropped, ev_overflow <= 1, and the pending bit is still cleared.
  - Push and pop while non-empty and non-full: occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow flag:
  - ev_overflow_clr clears it.
  - If a drop and a clear occur in the same cycle, the flag ends at 1 (set wins).
- ev_ready while !ev_valid has no effect.

Test Plan:
- Reset, then hold tm1638_in = {8'h00 x4} for 10 ticks → keys = 0, no pulses, ev_valid = 0.
- Bench parameters SAMPLE_PERIOD = 16, DEBOUNCE_SAMPLES = 3. Set tm1638_in[2] = 8'h01 → after the 3rd tick, keys = 8'h04 and key_pressed = 8'h04 for exactly 1 cycle; FIFO head = {pressed = 1, key = 2}; ev_ready = 1 pops it and ev_valid drops.
- Bounce: tm1638_in[0][4] toggles 1,0,1,0 on successive ticks → keys[4] never changes, no events; then hold 1 for 3 ticks → one press event for key 4.
- Simultaneous change: all of tm1638_in = 8'h11 (all 8 keys pressed) with ev_ready = 0 and FIFO_DEPTH = 8 → 8 press events queued in order key 0..7 with no overflow. Releasing all with ev_ready = 0 → 8 drops, ev_overflow = 1. Pulse ev_overflow_clr → ev_overflow = 0.
- Full FIFO with ev_ready = 1 on the cycle a new event is pushed → no drop, occupancy stays 8, ev_overflow remains 0.
- reset = 0 asserted while 3 events are queued and a key is mid-debounce → next cycle all outputs are 0 and FIFO empty. The held key produces a press event only after DEBOUNCE_SAMPLES fresh ticks.

Source files
------------

// File: rtl/tm1638_key_events.sv
// TM1638 key-scan consumer: decodes the 8 LED&KEY switches, debounces them on a
// periodic sample tick, and emits level, pulse and FIFO-queued press/release events.
module tm1638_key_events #(
    parameter logic [31:0] SAMPLE_PERIOD    = 32'd250_000,
    parameter int unsigned DEBOUNCE_SAMPLES = 3,
    parameter int unsigned FIFO_DEPTH       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tm1638_in [4],
    output logic [7:0] keys_raw,
    output logic [7:0] keys,
    output logic [7:0] key_pressed,
    output logic [7:0] key_released,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       ev_pressed,
    output logic [2:0] ev_key,
    output logic       ev_overflow,
    input  logic       ev_overflow_clr
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  DB_MAX = 4'(DEBOUNCE_SAMPLES - 1);

    logic [31:0]   scnt;
    logic          tick;
    logic [7:0]    dec;
    logic [7:0]    unused_bits;
    logic [3:0]    cnt [8];
    logic [7:0]    flip;
    logic [7:0]    pending;
    logic [7:0]    pend_type;
    logic [2:0]    sel;
    logic          push;
    logic [7:0]    clr_mask;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          do_push;

    assign tick = (scnt == '0);

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            dec[i]     = tm1638_in[i][0];
            dec[i + 4] = tm1638_in[i][4];
        end
    end
    assign unused_bits = tm1638_in[0] ^ tm1638_in[1] ^ tm1638_in[2] ^ tm1638_in[3];

    always_comb begin
        flip = '0;
        for (int unsigned i = 0; i < 8; i++)
            flip[i] = tick && (dec[i] != keys[i]) && (cnt[i] == DB_MAX);
    end

    // Reverse scan so the last hit, i.e. the lowest pending index, wins.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < 8; i++)
            if (pending[7 - i]) sel = 3'(7 - i);
    end
    assign push     = |pending;
    assign clr_mask = push ? (8'b1 << sel) : '0;

    assign ev_valid   = (count != '0);
    assign full       = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop        = ev_valid && ev_ready;
    assign do_push    = push && (!full || pop);
    assign ev_pressed = ev_valid && mem[rd_ptr][3];
    assign ev_key     = ev_valid ? mem[rd_ptr][2:0] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            scnt         <= SAMPLE_PERIOD - 32'd1;
            keys_raw     <= '0;
            keys         <= '0;
            key_pressed  <= '0;
            key_released <= '0;
            pending      <= '0;
            pend_type    <= '0;
            for (int unsigned i = 0; i < 8; i++) cnt[i] <= '0;
        end else begin
            key_pressed  <= '0;
            key_released <= '0;
            scnt         <= tick ? (SAMPLE_PERIOD - 32'd1) : (scnt - 32'd1);
            if (tick) begin
                keys_raw <= dec;
                for (int unsigned i = 0; i < 8; i++) begin
                    if (dec[i] == keys[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == DB_MAX) begin
                        keys[i]         <= dec[i];
                        cnt[i]          <= '0;
                        key_pressed[i]  <= dec[i];
                        key_released[i] <= !dec[i];
                    end else begin
                        cnt[i] <= cnt[i] + 4'd1;
                    end
                end
            end
            pending <= (pending & ~clr_mask) | flip;
            for (int unsigned i = 0; i < 8; i++)
                if (flip[i]) pend_type[i] <= dec[i];
        end
    end

    // A pending bit is consumed whether or not the FIFO had room for it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ev_overflow <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {pend_type[sel], sel};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (push && full && !pop)
                ev_overflow <= 1'b1;
            else if (ev_overflow_clr)
                ev_overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tm1638_key_events.sv
// Directed bench for tm1638_key_events with SAMPLE_PERIOD=16, DEBOUNCE_SAMPLES=3,
// FIFO_DEPTH=8; expected values are hand-derived from the tick timeline.
module tb_tm1638_key_events;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tm [4];
    logic [7:0] keys_raw, keys, key_pressed, key_released;
    logic       ev_valid, ev_ready, ev_pressed, ev_overflow, ev_overflow_clr;
    logic [2:0] ev_key;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         since_rst = 0;

    tm1638_key_events #(
        .SAMPLE_PERIOD    (32'd16),
        .DEBOUNCE_SAMPLES (3),
        .FIFO_DEPTH       (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .tm1638_in       (tm),
        .keys_raw        (keys_raw),
        .keys            (keys),
        .key_pressed     (key_pressed),
        .key_released    (key_released),
        .ev_valid        (ev_valid),
        .ev_ready        (ev_ready),
        .ev_pressed      (ev_pressed),
        .ev_key          (ev_key),
        .ev_overflow     (ev_overflow),
        .ev_overflow_clr (ev_overflow_clr)
    );

    always #5 clk = ~clk;

    // Edge count since the last reset edge; every 16th edge is a sample tick.
    always @(posedge clk) since_rst <= !reset ? 0 : since_rst + 1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_tick();
        do begin
            @(posedge clk);
            #1;
        end while (since_rst % 16 != 0);
        @(negedge clk);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [2:0] k);
        check({tag, "_valid"}, 8'(ev_valid), 8'd1);
        check({tag, "_key"}, 8'(ev_key), 8'(k));
        check({tag, "_type"}, 8'(ev_pressed), 8'd1);
        ev_ready = 1'b1;
        cycle();
        ev_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_outputs"}, {keys_raw | keys | key_pressed | key_released}, 8'h00);
        check({tag, "_ev"}, {3'b0, ev_valid, ev_pressed, ev_key}, 8'h00);
        check({tag, "_ovf"}, 8'(ev_overflow), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; ev_ready = 1'b0; ev_overflow_clr = 1'b0;
        for (int i = 0; i < 4; i++) tm[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        reset = 1'b1;

        for (int t = 0; t < 10; t++) begin
            next_tick();
            check("idle_keys", keys, 8'h00);
            check("idle_pulse", key_pressed | key_released, 8'h00);
            check("idle_valid", 8'(ev_valid), 8'd0);
        end

        // Single key press on key 2.
        tm[2] = 8'h01;
        next_tick();
        next_tick();
        check("k2_early", keys, 8'h00);
        next_tick();
        check("k2_raw", keys_raw, 8'h04);
        check("k2_keys", keys, 8'h04);
        check("k2_pulse", key_pressed, 8'h04);
        check("k2_notyet", 8'(ev_valid), 8'd0);
        cycle();
        check("k2_pulse_end", key_pressed, 8'h00);
        pop_check("k2_ev", 3'd2);
        check("k2_popped", 8'(ev_valid), 8'd0);

        // Bounce on key 4 never reaches the debounce count.
        for (int b = 0; b < 4; b++) begin
            tm[0] = (b % 2 == 0) ? 8'h10 : 8'h00;
            next_tick();
            if (b == 0) check("bnc_raw", keys_raw, 8'h14);
            check("bnc_keys", keys, 8'h04);
            check("bnc_valid", 8'(ev_valid), 8'd0);
        end
        tm[0] = 8'h10;
        next_tick();
        next_tick();
        check("k4_early", keys, 8'h04);
        next_tick();
        check("k4_keys", keys, 8'h14);
        check("k4_pulse", key_pressed, 8'h10);
        cycle();
        pop_check("k4_ev", 3'd4);

        // Release all, draining with ready held high.
        for (int i = 0; i < 4; i++) tm[i] = 8'h00;
        ev_ready = 1'b1;
        repeat (3) next_tick();
        check("rel_pulse", key_released, 8'h14);
        next_tick();
        ev_ready = 1'b0;
        check("rel_keys", keys, 8'h00);
        check("rel_empty", 8'(ev_valid), 8'd0);

        // All eight pressed together, FIFO fills exactly.
        for (int i = 0; i < 4; i++) tm[i] = 8'h11;
        repeat (3) next_tick();
        check("all_keys", keys, 8'hFF);
        check("all_pulse", key_pressed, 8'hFF);
        repeat (8) cycle();
        check("all_valid", 8'(ev_valid), 8'd1);
        check("all_head", 8'(ev_key), 8'd0);
        check("all_noovf", 8'(ev_overflow), 8'd0);

        // Release all with FIFO full: all eight dropped.
        for (int i = 0; i < 4; i++) tm[i] = 8'h00;
        repeat (3) next_tick();
        check("drop_pulse", key_released, 8'hFF);
        repeat (8) cycle();
        check("drop_ovf", 8'(ev_overflow), 8'd1);
        check("drop_head", 8'(ev_key), 8'd0);
        ev_overflow_clr = 1'b1;
        cycle();
        ev_overflow_clr = 1'b0;
        check("ovf_clr", 8'(ev_overflow), 8'd0);

        // Push into a full FIFO on the same edge as a pop.
        tm[0] = 8'h01;
        repeat (3) next_tick();
        check("full_keys", keys, 8'h01);
        ev_ready = 1'b1;
        cycle();
        ev_ready = 1'b0;
        check("full_noovf", 8'(ev_overflow), 8'd0);
        for (int k = 1; k < 8; k++) pop_check("drain", 3'(k));
        pop_check("drain_new", 3'd0);
        check("drain_empty", 8'(ev_valid), 8'd0);

        // Reset with three events queued and key 4 mid-debounce.
        tm[1] = 8'h01; tm[2] = 8'h01; tm[3] = 8'h01;
        repeat (3) next_tick();
        check("pre_keys", keys, 8'h0F);
        repeat (4) cycle();
        check("pre_valid", 8'(ev_valid), 8'd1);
        tm[0] = 8'h11;
        next_tick();
        reset = 1'b0;
        cycle();
        check_idle("midrst");
        reset = 1'b1;
        next_tick();
        next_tick();
        check("post_keys", keys, 8'h00);
        check("post_valid", 8'(ev_valid), 8'd0);
        next_tick();
        check("post_keys3", keys, 8'h1F);
        check("post_pulse", key_pressed, 8'h1F);
        cycle();
        pop_check("post_ev", 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
